// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port between NUM_PORTS writeback
// sources. One write is granted per cycle, round-robin starting from a
// priority pointer. Writes addressed to x0 are absorbed immediately, without
// taking the grant or moving the pointer. The write-port outputs and the
// one-hot grant are registered, so a grant in cycle N appears on rf_wr_* in N+1.
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   enable_i      0 = pipeline halt: no grants, no x0 absorbs, pointer frozen
//   req_addr_i    destination register per requester (packed, port 0 in LSBs)
//   req_data_i    write data per requester (packed, port 0 in LSBs)
//   req_valid_i   requester holds a write
//   req_ready_o   write accepted this cycle (combinational)
//   rf_wr_en_o    register-file write strobe (registered)
//   rf_wr_addr_o  register-file write address (registered, holds last value)
//   rf_wr_data_o  register-file write data (registered, holds last value)
//   grant_o       one-hot port owning the current rf_wr_* (registered)
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_data_i,
    input  logic [NUM_PORTS-1:0]          req_valid_i,
    output logic [NUM_PORTS-1:0]          req_ready_o,
    output logic                          rf_wr_en_o,
    output logic [ADDR_W-1:0]             rf_wr_addr_o,
    output logic [DATA_W-1:0]             rf_wr_data_o,
    output logic [NUM_PORTS-1:0]          grant_o
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PTR_W-1:0]     ptr_q,      ptr_d;
    logic                 wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0]    wr_addr_q,  wr_addr_d;
    logic [DATA_W-1:0]    wr_data_q,  wr_data_d;
    logic [NUM_PORTS-1:0] grant_q,    grant_d;

    logic [NUM_PORTS-1:0] sink;
    logic [NUM_PORTS-1:0] gnt_vec;
    logic                 found;
    int                   idx;

    always_comb begin
        sink      = '0;
        gnt_vec   = '0;
        found     = 1'b0;
        idx       = 0;
        ptr_d     = ptr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        for (int k = 0; k < NUM_PORTS; k++) begin
            sink[k] = req_valid_i[k] && (req_addr_i[k*ADDR_W +: ADDR_W] == '0);
        end

        // Scan from the pointer upward (mod NUM_PORTS); the first valid
        // non-x0 requester wins.
        if (enable_i) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = (int'(ptr_q) + k) % NUM_PORTS;
                if (!found && req_valid_i[idx] &&
                    (req_addr_i[idx*ADDR_W +: ADDR_W] != '0)) begin
                    found        = 1'b1;
                    gnt_vec[idx] = 1'b1;
                    wr_addr_d    = req_addr_i[idx*ADDR_W +: ADDR_W];
                    wr_data_d    = req_data_i[idx*DATA_W +: DATA_W];
                    ptr_d        = PTR_W'((idx + 1) % NUM_PORTS);
                end
            end
        end

        wr_en_d = found;
        grant_d = gnt_vec;
    end

    // Ready is forced low while reset is asserted so no requester believes
    // a write was taken that the reset is about to discard.
    assign req_ready_o = (rst_ni && enable_i) ? (sink | gnt_vec) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            grant_q   <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            grant_q   <= grant_d;
        end
    end

    assign rf_wr_en_o   = wr_en_q;
    assign rf_wr_addr_o = wr_addr_q;
    assign rf_wr_data_o = wr_data_q;
    assign grant_o      = grant_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int NP = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic [AW-1:0]  a [NP];
    logic [DW-1:0]  d [NP];
    logic [NP-1:0]  v;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_data;
    logic [NP-1:0]  ready;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic [NP-1:0]  grant;

    int n_checks = 0;
    int n_pass   = 0;

    always_comb begin
        req_addr = {a[3], a[2], a[1], a[0]};
        req_data = {d[3], d[2], d[1], d[0]};
    end

    regfile_write_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (en),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .req_valid_i  (v),
        .req_ready_o  (ready),
        .rf_wr_en_o   (wr_en),
        .rf_wr_addr_o (wr_addr),
        .rf_wr_data_o (wr_data),
        .grant_o      (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        for (int i = 0; i < NP; i++) begin
            a[i] = AW'(i + 1);
            d[i] = 32'h1000_0000 + i;
        end
        v = 4'hF;
        #1;
        n_checks++;
        if (ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", ready); else n_pass++;
        n_checks++;
        if (wr_en !== 1'b0) $display("FAIL reset_wr_en got=%b exp=0", wr_en); else n_pass++;
        n_checks++;
        if (grant !== 4'b0000) $display("FAIL reset_grant got=%b exp=0000", grant); else n_pass++;
        n_checks++;
        if (wr_addr !== 5'd0 || wr_data !== 32'd0)
            $display("FAIL reset_addr_data got=%0d/%h exp=0/0", wr_addr, wr_data);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ready !== 4'b0001) $display("FAIL reset_first_ready got=%b exp=0001", ready); else n_pass++;
    endtask

    // All four ports valid continuously: writes appear 1,2,3,4,1,... each cycle.
    task automatic test_round_robin();
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== AW'((i % 4) + 1) ||
                grant !== NP'(1 << (i % 4)) || wr_data !== (32'h1000_0000 + (i % 4)))
                $display("FAIL rr_seq[%0d] got en=%b addr=%0d grant=%b data=%h exp en=1 addr=%0d grant=%b",
                         i, wr_en, wr_addr, grant, wr_data, (i % 4) + 1, 4'(1 << (i % 4)));
            else n_pass++;
        end
        v = 4'b0000;
    endtask

    // Pointer is 0 here.
    task automatic test_x0_absorb();
        a[1] = 5'd0;
        a[2] = 5'd7;
        d[2] = 32'hDEAD_BEEF;
        v    = 4'b0110;
        #1;
        n_checks++;
        if (ready !== 4'b0110) $display("FAIL x0_ready got=%b exp=0110", ready); else n_pass++;
        step();
        v = 4'b0000;
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'hDEAD_BEEF || grant !== 4'b0100)
            $display("FAIL x0_write got en=%b addr=%0d data=%h grant=%b exp en=1 addr=7 data=deadbeef grant=0100",
                     wr_en, wr_addr, wr_data, grant);
        else n_pass++;
        step();
        n_checks++;
        if (wr_en !== 1'b0 || grant !== 4'b0000)
            $display("FAIL x0_idle got en=%b grant=%b exp en=0 grant=0000", wr_en, grant);
        else n_pass++;
    endtask

    // Pointer is 3 here.
    task automatic test_wrap();
        a[0] = 5'd5;
        a[3] = 5'd6;
        v    = 4'b1001;
        #1;
        n_checks++;
        if (ready !== 4'b1000) $display("FAIL wrap_ready3 got=%b exp=1000", ready); else n_pass++;
        step();
        v = 4'b0001;
        n_checks++;
        if (grant !== 4'b1000 || wr_addr !== 5'd6)
            $display("FAIL wrap_grant3 got grant=%b addr=%0d exp grant=1000 addr=6", grant, wr_addr);
        else n_pass++;
        step();
        n_checks++;
        if (grant !== 4'b0001 || wr_addr !== 5'd5)
            $display("FAIL wrap_grant0 got grant=%b addr=%0d exp grant=0001 addr=5", grant, wr_addr);
        else n_pass++;
        v = 4'b1000;
        #1;
        n_checks++;
        if (ready !== 4'b1000) $display("FAIL wrap_only3 got=%b exp=1000", ready); else n_pass++;
        step();
        v = 4'b1001;
        #1;
        n_checks++;
        if (ready !== 4'b0001) $display("FAIL wrap_ptr_to0 got=%b exp=0001", ready); else n_pass++;
        step();
        v = 4'b0000;
    endtask

    // Pointer is 1 here.
    task automatic test_enable();
        a[2] = 5'd9;
        d[2] = 32'h0000_0099;
        v    = 4'b0100;
        step();
        en = 1'b0;
        v  = 4'b1011;
        a[1] = 5'd0;
        #1;
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd9 || grant !== 4'b0100)
            $display("FAIL en_completes got en=%b addr=%0d grant=%b exp en=1 addr=9 grant=0100",
                     wr_en, wr_addr, grant);
        else n_pass++;
        n_checks++;
        if (ready !== 4'b0000) $display("FAIL en_ready_off got=%b exp=0000", ready); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (wr_en !== 1'b0 || grant !== 4'b0000 || ready !== 4'b0000)
                $display("FAIL en_halt[%0d] got en=%b grant=%b ready=%b exp 0/0000/0000",
                         i, wr_en, grant, ready);
            else n_pass++;
        end
        v  = 4'b1001;
        en = 1'b1;
        #1;
        n_checks++;
        if (ready !== 4'b1000) $display("FAIL en_resume_ready got=%b exp=1000", ready); else n_pass++;
        step();
        v = 4'b0000;
        n_checks++;
        if (grant !== 4'b1000 || wr_en !== 1'b1)
            $display("FAIL en_resume_grant got grant=%b en=%b exp 1000/1", grant, wr_en);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        a[0] = 5'd3;
        v    = 4'b0001;
        step();
        v = 4'b0000;
        n_checks++;
        if (wr_en !== 1'b1) $display("FAIL arst_pre got=%b exp=1", wr_en); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || grant !== 4'b0000 || wr_addr !== 5'd0 || wr_data !== 32'd0)
            $display("FAIL arst_drop got en=%b grant=%b addr=%0d data=%h exp all 0",
                     wr_en, grant, wr_addr, wr_data);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Randomized traffic checked against a reference of the arbitration rules.
    task automatic test_random();
        int            mptr = 0;
        bit            exp_en = 0;
        logic [AW-1:0] exp_addr = '0;
        logic [DW-1:0] exp_data = '0;
        logic [NP-1:0] exp_grant = '0;
        logic [NP-1:0] exp_ready;
        bit            pend [NP];
        int            wait_cnt [NP];
        logic [DW-1:0] ref_rf [32];
        logic [DW-1:0] dut_rf [32];
        int            g;
        int            p;
        int            rf_bad = 0;

        for (int i = 0; i < 32; i++) begin
            ref_rf[i] = '0;
            dut_rf[i] = '0;
        end
        for (int i = 0; i < NP; i++) begin
            pend[i]     = 0;
            wait_cnt[i] = 0;
        end

        for (int cyc = 0; cyc < 400; cyc++) begin
            n_checks++;
            if (wr_en !== exp_en || grant !== exp_grant ||
                wr_addr !== exp_addr || wr_data !== exp_data)
                $display("FAIL rand_out[%0d] got en=%b g=%b a=%0d d=%h exp en=%b g=%b a=%0d d=%h",
                         cyc, wr_en, grant, wr_addr, wr_data, exp_en, exp_grant, exp_addr, exp_data);
            else n_pass++;
            if (wr_en === 1'b1) dut_rf[wr_addr] = wr_data;

            for (int i = 0; i < NP; i++) begin
                if (!pend[i] && ($urandom_range(0, 99) < 70)) begin
                    pend[i] = 1;
                    a[i] = ($urandom_range(0, 4) == 0) ? 5'd0 : AW'($urandom_range(1, 8));
                    d[i] = $urandom;
                end
                v[i] = pend[i];
            end
            en = ($urandom_range(0, 9) != 0);
            #1;

            exp_ready = '0;
            g = -1;
            if (en) begin
                for (int i = 0; i < NP; i++)
                    if (pend[i] && a[i] == 0) exp_ready[i] = 1'b1;
                for (int off = 0; off < NP; off++) begin
                    p = (mptr + off) % NP;
                    if (g < 0 && pend[p] && a[p] != 0) g = p;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            n_checks++;
            if (ready !== exp_ready)
                $display("FAIL rand_ready[%0d] got=%b exp=%b", cyc, ready, exp_ready);
            else n_pass++;

            // Fairness measured on DUT handshakes.
            for (int i = 0; i < NP; i++) begin
                if (en && pend[i] && a[i] != 0) begin
                    if (ready[i] === 1'b1) begin
                        n_checks++;
                        if (wait_cnt[i] > NP - 1)
                            $display("FAIL rand_fair port=%0d waited=%0d max=%0d", i, wait_cnt[i], NP - 1);
                        else n_pass++;
                        wait_cnt[i] = 0;
                    end else begin
                        wait_cnt[i]++;
                    end
                end
            end

            if (g >= 0) begin
                exp_en    = 1;
                exp_addr  = a[g];
                exp_data  = d[g];
                exp_grant = NP'(1 << g);
                ref_rf[a[g]] = d[g];
                mptr = (g + 1) % NP;
            end else begin
                exp_en    = 0;
                exp_grant = '0;
            end
            for (int i = 0; i < NP; i++)
                if (exp_ready[i]) pend[i] = 0;
            step();
        end

        n_checks++;
        if (wr_en !== exp_en || wr_addr !== exp_addr || wr_data !== exp_data)
            $display("FAIL rand_last got en=%b a=%0d d=%h exp en=%b a=%0d d=%h",
                     wr_en, wr_addr, wr_data, exp_en, exp_addr, exp_data);
        else n_pass++;
        if (wr_en === 1'b1) dut_rf[wr_addr] = wr_data;

        for (int i = 0; i < 32; i++)
            if (dut_rf[i] !== ref_rf[i]) rf_bad++;
        n_checks++;
        if (rf_bad != 0 || dut_rf[0] !== 32'd0)
            $display("FAIL rand_rf_contents mismatched_regs=%0d x0=%h exp 0 mismatches x0=0", rf_bad, dut_rf[0]);
        else n_pass++;
        v = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_x0_absorb();
        test_wrap();
        test_enable();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
